// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the I/X/W pipeline datapath and its hazard/stall controller.
// The master side drives hazard sources; the slave side (controller) drives stall/flush controls.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             icache_ready;
  logic             dcache_ready;
  logic             x_mem_req;
  logic             x_is_load;
  logic [4:0]       x_rd;
  logic [4:0]       i_rs1;
  logic [4:0]       i_rs2;
  logic             i_uses_rs1;
  logic             i_uses_rs2;
  logic             x_redirect;
  logic             pipe_reset;
  logic             stall_pc;
  logic             stall_1_2;
  logic             stall_2_3;
  logic             flush_1;
  logic             busy;
  logic [CNT_W-1:0] stall_count;
  logic             mem_timeout;

  modport master (
    output icache_ready, dcache_ready, x_mem_req, x_is_load, x_rd,
           i_rs1, i_rs2, i_uses_rs1, i_uses_rs2, x_redirect,
    input  pipe_reset, stall_pc, stall_1_2, stall_2_3, flush_1, busy,
           stall_count, mem_timeout
  );

  modport slave (
    input  icache_ready, dcache_ready, x_mem_req, x_is_load, x_rd,
           i_rs1, i_rs2, i_uses_rs1, i_uses_rs2, x_redirect,
    output pipe_reset, stall_pc, stall_1_2, stall_2_3, flush_1, busy,
           stall_count, mem_timeout
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for the 3-stage I/X/W pipeline: post-reset warm-up,
// memory wait-state stalls, X-stage redirect flush and load-use bubbles, plus stall statistics.
module pipeline_ctrl #(
  parameter int unsigned RESET_HOLD = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic            clk,
  input  logic            reset,
  pipeline_ctrl_if.slave  pif
);

  localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int unsigned WAIT_W = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_MEM_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic mem_stall;
  logic load_use;
  logic pipe_reset_c, stall_pc_c, stall_1_2_c, stall_2_3_c, flush_1_c;

  // Control outputs are combinational so they settle before the negedge latch of the transfer registers.
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    pipe_reset_c  = 1'b0;
    stall_pc_c    = 1'b0;
    stall_1_2_c   = 1'b0;
    stall_2_3_c   = 1'b0;
    flush_1_c     = 1'b0;

    mem_stall = !pif.icache_ready | (pif.x_mem_req & !pif.dcache_ready);
    load_use  = pif.x_is_load & (pif.x_rd != 5'd0) &
                ((pif.i_uses_rs1 & (pif.i_rs1 == pif.x_rd)) |
                 (pif.i_uses_rs2 & (pif.i_rs2 == pif.x_rd)));

    case (state_q)
      S_HOLD: begin
        pipe_reset_c = 1'b1;
        stall_pc_c   = 1'b1;
        stall_1_2_c  = 1'b1;
        stall_2_3_c  = 1'b1;
        flush_1_c    = 1'b1;
        hold_cnt_d   = hold_cnt_q + HOLD_W'(1);
        if (hold_cnt_q == HOLD_W'(RESET_HOLD - 1)) begin
          state_d    = S_RUN;
          hold_cnt_d = '0;
        end
      end
      default: begin
        // Memory stall freezes everything; a pending redirect waits until it clears.
        if (mem_stall) begin
          stall_pc_c  = 1'b1;
          stall_1_2_c = 1'b1;
          stall_2_3_c = 1'b1;
          state_d     = S_MEM_WAIT;
        end else begin
          state_d = S_RUN;
          if (pif.x_redirect) begin
            flush_1_c = 1'b1;
          end else if (load_use) begin
            stall_pc_c = 1'b1;
            flush_1_c  = 1'b1;
          end
        end
      end
    endcase
  end

  // Wait-state tracking and saturating statistics.
  always_comb begin
    wait_cnt_d    = '0;
    stall_count_d = stall_count_q;
    if (mem_stall) begin
      wait_cnt_d = (wait_cnt_q == WAIT_W'(WAIT_LIMIT)) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
    end
    mem_timeout_d = mem_timeout_q | (mem_stall & (wait_cnt_d == WAIT_W'(WAIT_LIMIT)));
    if (mem_stall && (state_q != S_HOLD) && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_HOLD;
      hold_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      stall_count_q <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign pif.pipe_reset  = pipe_reset_c;
  assign pif.stall_pc    = stall_pc_c;
  assign pif.stall_1_2   = stall_1_2_c;
  assign pif.stall_2_3   = stall_2_3_c;
  assign pif.flush_1     = flush_1_c;
  assign pif.busy        = pipe_reset_c | stall_pc_c | stall_1_2_c | stall_2_3_c | flush_1_c;
  assign pif.stall_count = stall_count_q;
  assign pif.mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: warm-up hold, memory stalls, load-use, redirect,
// wait-state timeout and asynchronous reset mid-stall, with hand-computed expectations.
module tb_pipeline_ctrl;

  // Control vector order: {pipe_reset, stall_pc, stall_1_2, stall_2_3, flush_1, busy}
  localparam logic [5:0] C_ALL  = 6'b111111;
  localparam logic [5:0] C_IDLE = 6'b000000;
  localparam logic [5:0] C_MEM  = 6'b011101;
  localparam logic [5:0] C_LU   = 6'b010011;
  localparam logic [5:0] C_RD   = 6'b000011;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(32)) pif ();

  pipeline_ctrl #(
    .RESET_HOLD (4),
    .CNT_W      (32),
    .WAIT_LIMIT (255)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pif   (pif)
  );

  logic [5:0] ctl;
  assign ctl = {pif.pipe_reset, pif.stall_pc, pif.stall_1_2, pif.stall_2_3, pif.flush_1, pif.busy};

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pif.icache_ready = 1'b1;
    pif.dcache_ready = 1'b1;
    pif.x_mem_req    = 1'b0;
    pif.x_is_load    = 1'b0;
    pif.x_rd         = 5'd0;
    pif.i_rs1        = 5'd0;
    pif.i_rs2        = 5'd0;
    pif.i_uses_rs1   = 1'b0;
    pif.i_uses_rs2   = 1'b0;
    pif.x_redirect   = 1'b0;
  endtask

  // Release reset and expect exactly four held cycles before RUN.
  task automatic release_and_hold(input string tag);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk({tag, "_hold"}, 32'(ctl), 32'(C_ALL));
      cyc();
    end
    #1 chk({tag, "_run"}, 32'(ctl), 32'(C_IDLE));
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #1;
    chk("rst_ctl", 32'(ctl), 32'(C_ALL));
    chk("rst_count", pif.stall_count, 32'd0);
    chk("rst_timeout", 32'(pif.mem_timeout), 32'd0);
    repeat (3) @(posedge clk);
    release_and_hold("boot");
    chk("boot_count", pif.stall_count, 32'd0);

    // Instruction-fetch wait states for three cycles.
    pif.icache_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("istall_ctl", 32'(ctl), 32'(C_MEM));
      cyc();
    end
    pif.icache_ready = 1'b1;
    #1 chk("istall_done", 32'(ctl), 32'(C_IDLE));
    chk("istall_count", pif.stall_count, 32'd3);

    // Load-use hazard through rs1, then its natural clearance.
    cyc();
    pif.x_is_load = 1'b1; pif.x_rd = 5'd5; pif.i_rs1 = 5'd5; pif.i_uses_rs1 = 1'b1;
    #1 chk("lu_rs1", 32'(ctl), 32'(C_LU));
    cyc();
    pif.x_is_load = 1'b0;
    #1 chk("lu_clear", 32'(ctl), 32'(C_IDLE));
    pif.x_is_load = 1'b1; pif.x_rd = 5'd0; pif.i_rs1 = 5'd0;
    #1 chk("lu_x0", 32'(ctl), 32'(C_IDLE));
    pif.x_rd = 5'd5; pif.i_rs1 = 5'd5; pif.i_uses_rs1 = 1'b0;
    #1 chk("lu_unused", 32'(ctl), 32'(C_IDLE));
    pif.i_uses_rs2 = 1'b1; pif.i_rs2 = 5'd5;
    #1 chk("lu_rs2", 32'(ctl), 32'(C_LU));
    pif.x_redirect = 1'b1;
    #1 chk("redir_over_lu", 32'(ctl), 32'(C_RD));
    cyc();
    idle_inputs();

    // Redirect held across a data-cache stall.
    pif.x_mem_req = 1'b1; pif.dcache_ready = 1'b0; pif.x_redirect = 1'b1;
    #1 chk("redir_dstall0", 32'(ctl), 32'(C_MEM));
    cyc();
    #1 chk("redir_dstall1", 32'(ctl), 32'(C_MEM));
    cyc();
    pif.dcache_ready = 1'b1;
    #1 chk("redir_release", 32'(ctl), 32'(C_RD));
    chk("redir_count", pif.stall_count, 32'd5);
    cyc();
    idle_inputs();

    // Long data stall: timeout exactly at the 255th stalled edge.
    pif.x_mem_req = 1'b1; pif.dcache_ready = 1'b0;
    repeat (254) cyc();
    chk("timeout_pre", 32'(pif.mem_timeout), 32'd0);
    chk("timeout_pre_ctl", 32'(ctl), 32'(C_MEM));
    cyc();
    chk("timeout_set", 32'(pif.mem_timeout), 32'd1);
    idle_inputs();
    cyc();
    cyc();
    chk("timeout_sticky", 32'(pif.mem_timeout), 32'd1);
    chk("timeout_count", pif.stall_count, 32'd260);
    chk("timeout_ctl", 32'(ctl), 32'(C_IDLE));

    // Asynchronous reset in the middle of a memory stall.
    pif.icache_ready = 1'b0;
    cyc();
    #1 chk("mw_ctl", 32'(ctl), 32'(C_MEM));
    #1 reset = 1'b0;
    #1 chk("arst_ctl", 32'(ctl), 32'(C_ALL));
    chk("arst_count", pif.stall_count, 32'd0);
    chk("arst_timeout", 32'(pif.mem_timeout), 32'd0);
    pif.icache_ready = 1'b1;
    release_and_hold("rerun");
    chk("rerun_count", pif.stall_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
